// File: rtl/display_pkg.sv
// Shared constants for the display path: converter state encoding, digit count
// and the double-dabble digit-adjust constants.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;

  localparam int BCD_DIGITS = 5;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= ADJ_THRESH) ? digit + ADJ_ADD : digit;

endmodule

// File: rtl/bin16_to_bcd.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with a start/busy/done handshake and a held packed-BCD output register.
module bin16_to_bcd
  import display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WIDTH-1:0]      shreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   scratch_adj;
  logic [4*DIGITS-1:0]   scratch_next;
  logic                  unused_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[4*g +: 4]),
      .adj   (scratch_adj[4*g +: 4])
    );
  end

  // Adjusted digits shift left as one vector; the top bit can never be set
  // for a legal input because DIGITS covers the full binary range.
  assign scratch_next = {scratch_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
  assign unused_msb   = scratch_adj[4*DIGITS-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      scratch <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_next;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_ONE;
          if (bit_cnt == CNT_LAST) begin
            bcd   <= scratch_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bin16_to_bcd.md
# bin16_to_bcd

Sequential binary-to-BCD converter placed directly downstream of the 16-bit event/time counter. It samples the counter's 16-bit `count` value on a `start` request and converts it with the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents five packed BCD digits to the seven-segment display driver. A start/busy/done handshake lets the display refresh logic request a new conversion whenever the counter changes or on a periodic refresh tick.

## Interface
- `WIDTH`, 16, binary input width (matches the counter)
- `DIGITS`, 5, BCD digits produced; must be ≥ ceil(WIDTH·log10 2), which is 5 for 16 bits
- `clk`  input  1  system clock, all logic on rising edge
- `reset_n`  input  1  synchronous, active-low reset
- `start`  input  1  conversion request; sampled only when idle
- `bin_in`  input  WIDTH  binary value to convert; captured on the accepted `start` edge
- `busy`  output  1  high while a conversion is in progress
- `done`  output  1  one-cycle pulse when `bcd` has just been updated
- `bcd`  output  4·DIGITS  packed result; digit 0 (ones) is bits [3:0]; held until the next completion

## Operation
- FSM states: IDLE, SHIFT.
  - IDLE: if `start`=1, latch `bin_in` into the shift register, clear the BCD scratch register, set `bit_cnt`=0 and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, every scratch digit ≥5 gets +3 (all digits adjusted in parallel, before the shift). Then {scratch, shift} is shifted left 1 bit, with the MSB of shift entering scratch bit 0. `bit_cnt` increments.
  - On the shift where `bit_cnt`=WIDTH−1: the adjusted and shifted scratch is written to `bcd`, `done` is set to 1, and the FSM returns to IDLE.
- `start` while busy is ignored. It is not queued.
- `bin_in` changes after acceptance do not affect the running conversion.
- `done` is registered. It is deasserted on every cycle except the single cycle following the final shift.
- Digit add-3 arithmetic is 4-bit. No digit exceeds 9 after the final shift for any legal input.
- Unused states (if the encoding has spare codes) return to IDLE.
- Reset (`reset_n`=0 at a rising edge):
  - state=IDLE
  - `busy`=0, `done`=0, `bcd`=0
  - scratch, shift register and `bit_cnt` cleared
- Reset during a conversion aborts it. No `done` is produced.

## Timing
- Acceptance edge E0 (IDLE with `start`=1).
- `busy`=1 in the cycles after edges E0…E15. `busy` is 0 after edge E16.
- The final shift occurs at E16. `bcd` is valid and `done`=1 in the cycle after E16.
- Latency from accepted `start` to `done` is WIDTH cycles (16).
- `busy` is a registered output that equals (state==SHIFT).
- Back-to-back: `start` held high, or asserted during the `done` cycle, is accepted at the next edge (FSM is IDLE). Throughput is one conversion per WIDTH+1 cycles.
- `bcd` never shows partial results. It changes only on the completion edge.

## Structure
- Shared package `display_pkg` holds:
  - state encoding constants (ST_IDLE, ST_SHIFT)
  - BCD_DIGITS=5
  - the digit-adjust threshold constant (5) and add value (3)
- One natural sub-module is `bcd_digit_adj`: a 4-bit combinational "if ≥5 then +3" cell, instantiated DIGITS times with a generate loop.
- The top level owns:
  - the FSM
  - `bit_cnt`, which is clog2(WIDTH) bits wide (4 bits for 16)
  - the shift and scratch registers
  - the output register

## Test plan
- Reset, then `start` with `bin_in`=0x0000. Required: `busy` high for 16 cycles, then `done` pulse with `bcd`=0x00000.
- `bin_in`=0xFFFF (counter at its carry-out value). Required: `bcd`=0x65535 exactly 16 cycles after acceptance, and `done` high for exactly 1 cycle.
- `bin_in`=1234 (0x04D2). Required: `bcd`=0x01234. Then `bin_in`=9 (0x0009): `bcd`=0x00009 and the previous value is held until that `done`.
- During a conversion of 500, pulse `start` with `bin_in`=42 and also change `bin_in`. Required: `bcd`=0x00500. The second request is dropped and only one `done` occurs.
- Assert `reset_n`=0 at shift cycle 8 of a conversion of 0xFFFF. Required: next cycle `busy`=0, `done`=0, `bcd`=0x00000, and no later `done`.
- Hold `start`=1 with `bin_in` stepping 0xFFFE → 0xFFFF → 0x0000 (counter wrap). Required:
  - `done` pulses 17 cycles apart
  - `bcd` sequence 0x65534, 0x65535, 0x00000
